pc_unit: RTL and testbench

//   Parametrised program-counter unit for the multi-cycle core. Holds the PC and updates it
//   on enabled cycles from one of four sources: jump, conditional branch, call or return.

---
 rtl/pc_pkg.sv | 36 +++
 rtl/pc_ras.sv | 69 ++++++
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter constants: update-mode codes, branch-condition codes and the
// condition decode used by pc_unit (the control unit imports the same names).
package pc_pkg;

    localparam logic [1:0] PC_JUMP   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_CALL   = 2'b10;
    localparam logic [1:0] PC_RETURN = 2'b11;

    localparam logic [2:0] BT_EQ     = 3'b000;
    localparam logic [2:0] BT_NE     = 3'b001;
    localparam logic [2:0] BT_LT     = 3'b010;
    localparam logic [2:0] BT_GE     = 3'b011;
    localparam logic [2:0] BT_LE     = 3'b100;
    localparam logic [2:0] BT_GT     = 3'b101;
    localparam logic [2:0] BT_ALWAYS = 3'b110;
    localparam logic [2:0] BT_NEVER  = 3'b111;

    // Evaluate a branch condition against the ALU zero/negative flags.
    function automatic logic branch_cond(input logic [2:0] bt, input logic z, input logic n);
        logic result;
        result = 1'b0;
        case (bt)
            BT_EQ:     result = z;
            BT_NE:     result = !z;
            BT_LT:     result = n;
            BT_GE:     result = !n;
            BT_LE:     result = n | z;
            BT_GT:     result = !n & !z;
            BT_ALWAYS: result = 1'b1;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushes wrap over the oldest entry when full,
// pops on an empty stack are ignored and flagged.
module pc_ras #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] stack_reg [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             pop_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_MAX);
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign pop_ok    = pop && !empty;
    // ptr points at the next free slot, so the top of stack sits one below it
    assign top       = stack_reg[ptr_reg - PTR_ONE];

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        if (push) begin
            ptr_next   = ptr_reg + PTR_ONE;
            count_next = full ? count_reg : count_reg + CNT_ONE;
        end else if (pop_ok) begin
            ptr_next   = ptr_reg - PTR_ONE;
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    // Entry storage needs no reset: count_reg gates every read.
    always_ff @(posedge CLK) begin
        if (RST_N && push) begin
            stack_reg[ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with jump, conditional branch, call and return updates;
// call/return go through a circular return-address stack.
module pc_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             input_PCWrite,
    input  logic [1:0]       input_mode,
    input  logic [2:0]       input_branchType,
    input  logic [WIDTH-1:0] input_newPC,
    input  logic [WIDTH-1:0] input_returnAddr,
    input  logic             input_zero,
    input  logic             input_negative,
    output logic [WIDTH-1:0] output_PC,
    output logic             output_branchTaken,
    output logic             output_rasEmpty,
    output logic             output_rasFull,
    output logic             output_rasError
);

    import pc_pkg::*;

    logic [WIDTH-1:0] pc_reg;
    logic             taken_reg;
    logic             ras_error_reg;
    logic             cond_met;
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;

    assign cond_met = branch_cond(input_branchType, input_zero, input_negative);
    assign ras_push = input_PCWrite && (input_mode == PC_CALL);
    assign ras_pop  = input_PCWrite && (input_mode == PC_RETURN);

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (input_returnAddr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_reg        <= RESET_VECTOR;
            taken_reg     <= 1'b0;
            ras_error_reg <= 1'b0;
        end else if (!input_PCWrite) begin
            taken_reg <= 1'b0;
        end else begin
            case (input_mode)
                PC_JUMP: begin
                    pc_reg    <= input_newPC;
                    taken_reg <= 1'b1;
                end
                PC_BRANCH: begin
                    if (cond_met) begin
                        pc_reg <= input_newPC;
                    end
                    taken_reg <= cond_met;
                end
                PC_CALL: begin
                    pc_reg    <= input_newPC;
                    taken_reg <= 1'b1;
                    if (ras_overflow) begin
                        ras_error_reg <= 1'b1;
                    end
                end
                default: begin
                    // Return on an empty stack leaves the PC where it is.
                    if (ras_underflow) begin
                        taken_reg     <= 1'b0;
                        ras_error_reg <= 1'b1;
                    end else begin
                        pc_reg    <= ras_top;
                        taken_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign output_PC          = pc_reg;
    assign output_branchTaken = taken_reg;
    assign output_rasEmpty    = ras_empty;
    assign output_rasFull     = ras_full;
    assign output_rasError    = ras_error_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, branch-condition sweep, enable gating, nested calls,
// stack overflow, underflow and reset in the middle of a call sequence.
module tb_pc_unit;

    logic        CLK;
    logic        RST_N;
    logic        input_PCWrite;
    logic [1:0]  input_mode;
    logic [2:0]  input_branchType;
    logic [15:0] input_newPC;
    logic [15:0] input_returnAddr;
    logic        input_zero;
    logic        input_negative;
    logic [15:0] output_PC;
    logic        output_branchTaken;
    logic        output_rasEmpty;
    logic        output_rasFull;
    logic        output_rasError;

    int checks = 0;
    int errors = 0;

    pc_unit #(
        .WIDTH        (16),
        .RESET_VECTOR (16'h0000),
        .RAS_DEPTH    (4)
    ) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .input_PCWrite      (input_PCWrite),
        .input_mode         (input_mode),
        .input_branchType   (input_branchType),
        .input_newPC        (input_newPC),
        .input_returnAddr   (input_returnAddr),
        .input_zero         (input_zero),
        .input_negative     (input_negative),
        .output_PC          (output_PC),
        .output_branchTaken (output_branchTaken),
        .output_rasEmpty    (output_rasEmpty),
        .output_rasFull     (output_rasFull),
        .output_rasError    (output_rasError)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [1:0] mode, input logic [15:0] npc,
                         input logic [15:0] ra);
        input_PCWrite    = wr;
        input_mode       = mode;
        input_newPC      = npc;
        input_returnAddr = ra;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        drive(1'b1, 2'b00, 16'h1234, 16'h0000);
        tick();
        tick();
        checks++;
        if ({output_PC, output_branchTaken, output_rasEmpty, output_rasError} !== {16'h0000, 3'b010}) begin
            errors++;
            $display("FAIL reset_hold pc=%h tk=%b emp=%b err=%b exp pc=0000 tk=0 emp=1 err=0",
                     output_PC, output_branchTaken, output_rasEmpty, output_rasError);
        end
        RST_N = 1'b1;
        tick();
        checks++;
        if ({output_PC, output_branchTaken} !== {16'h1234, 1'b1}) begin
            errors++;
            $display("FAIL reset_release pc=%h tk=%b exp pc=1234 tk=1", output_PC, output_branchTaken);
        end
        $display("reset: pc=%h tk=%b", output_PC, output_branchTaken);
    endtask

    task automatic test_cond_sweep();
        // bit k of each entry: expected taken for flag pattern k (0: Z0N0, 1: Z0N1, 2: Z1N0)
        logic [2:0]  exp_tab [8];
        logic [15:0] exp_pc;
        logic        exp_tk;
        exp_tab = '{3'b100, 3'b011, 3'b010, 3'b101, 3'b110, 3'b001, 3'b111, 3'b000};
        for (int bt = 0; bt < 8; bt++) begin
            for (int f = 0; f < 3; f++) begin
                drive(1'b1, 2'b00, 16'h0000, 16'h0000);
                tick();
                drive(1'b1, 2'b01, 16'h0040, 16'h0000);
                input_branchType = 3'(bt);
                input_zero       = (f == 2);
                input_negative   = (f == 1);
                tick();
                exp_tk = exp_tab[bt][f];
                exp_pc = exp_tk ? 16'h0040 : 16'h0000;
                checks++;
                if ({output_PC, output_branchTaken} !== {exp_pc, exp_tk}) begin
                    errors++;
                    $display("FAIL cond bt=%0d z=%b n=%b pc=%h tk=%b exp pc=%h tk=%b", bt,
                             input_zero, input_negative, output_PC, output_branchTaken, exp_pc, exp_tk);
                end
                $display("cond bt=%0d z=%b n=%b pc=%h tk=%b", bt, input_zero, input_negative,
                         output_PC, output_branchTaken);
            end
        end
        input_zero     = 1'b0;
        input_negative = 1'b0;
    endtask

    task automatic test_enable_gating();
        drive(1'b1, 2'b00, 16'h0200, 16'h0000);
        tick();
        drive(1'b0, 2'b10, 16'h0100, 16'h0BAD);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({output_PC, output_branchTaken, output_rasEmpty} !== {16'h0200, 2'b01}) begin
                errors++;
                $display("FAIL gate cyc=%0d pc=%h tk=%b emp=%b exp pc=0200 tk=0 emp=1", i,
                         output_PC, output_branchTaken, output_rasEmpty);
            end
            $display("gate cyc=%0d pc=%h tk=%b", i, output_PC, output_branchTaken);
        end
    endtask

    task automatic test_nested_calls();
        logic [15:0] ret_exp [3];
        ret_exp = '{16'h0006, 16'h0004, 16'h0002};
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'b10, 16'h1000 + 16'(i), 16'(2 * i));
            tick();
            checks++;
            if ({output_PC, output_branchTaken, output_rasEmpty, output_rasFull} !==
                {16'h1000 + 16'(i), 3'b100}) begin
                errors++;
                $display("FAIL call%0d pc=%h tk=%b emp=%b full=%b exp pc=%h tk=1 emp=0 full=0", i,
                         output_PC, output_branchTaken, output_rasEmpty, output_rasFull, 16'h1000 + 16'(i));
            end
            $display("call%0d pc=%h", i, output_PC);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 16'hFFFF, 16'h0000);
            tick();
            checks++;
            if ({output_PC, output_branchTaken} !== {ret_exp[i], 1'b1}) begin
                errors++;
                $display("FAIL ret%0d pc=%h tk=%b exp pc=%h tk=1", i, output_PC, output_branchTaken, ret_exp[i]);
            end
            $display("ret%0d pc=%h", i, output_PC);
        end
        checks++;
        if ({output_rasEmpty, output_rasError} !== 2'b10) begin
            errors++;
            $display("FAIL nest_end emp=%b err=%b exp emp=1 err=0", output_rasEmpty, output_rasError);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] ret_exp [4];
        ret_exp = '{16'h0050, 16'h0040, 16'h0030, 16'h0020};
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 2'b10, 16'h2000, 16'(16 * i));
            tick();
            // full after the 4th push, error only once the 5th push wraps
            checks++;
            if ({output_rasFull, output_rasError} !== {(i >= 4), (i == 5)}) begin
                errors++;
                $display("FAIL ovf_push%0d full=%b err=%b exp full=%b err=%b", i, output_rasFull,
                         output_rasError, (i >= 4), (i == 5));
            end
            $display("ovf push%0d full=%b err=%b", i, output_rasFull, output_rasError);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 16'hFFFF, 16'h0000);
            tick();
            checks++;
            if ({output_PC, output_branchTaken} !== {ret_exp[i], 1'b1}) begin
                errors++;
                $display("FAIL ovf_ret%0d pc=%h tk=%b exp pc=%h tk=1", i, output_PC, output_branchTaken, ret_exp[i]);
            end
            $display("ovf ret%0d pc=%h", i, output_PC);
        end
        checks++;
        if ({output_rasEmpty, output_rasError} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_end emp=%b err=%b exp emp=1 err=1", output_rasEmpty, output_rasError);
        end
    endtask

    task automatic test_underflow_reset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        drive(1'b1, 2'b00, 16'h0300, 16'h0000);
        tick();
        drive(1'b1, 2'b11, 16'hFFFF, 16'h0000);
        tick();
        checks++;
        if ({output_PC, output_branchTaken, output_rasError} !== {16'h0300, 2'b01}) begin
            errors++;
            $display("FAIL underflow pc=%h tk=%b err=%b exp pc=0300 tk=0 err=1",
                     output_PC, output_branchTaken, output_rasError);
        end
        $display("underflow pc=%h err=%b", output_PC, output_rasError);
        drive(1'b1, 2'b10, 16'h0400, 16'h0302);
        tick();
        checks++;
        if ({output_PC, output_rasEmpty} !== {16'h0400, 1'b0}) begin
            errors++;
            $display("FAIL mid_call pc=%h emp=%b exp pc=0400 emp=0", output_PC, output_rasEmpty);
        end
        RST_N = 1'b0;
        tick();
        checks++;
        if ({output_PC, output_branchTaken, output_rasEmpty, output_rasError} !== {16'h0000, 3'b010}) begin
            errors++;
            $display("FAIL mid_reset pc=%h tk=%b emp=%b err=%b exp pc=0000 tk=0 emp=1 err=0",
                     output_PC, output_branchTaken, output_rasEmpty, output_rasError);
        end
        $display("mid reset pc=%h emp=%b err=%b", output_PC, output_rasEmpty, output_rasError);
        RST_N = 1'b1;
        drive(1'b1, 2'b11, 16'hFFFF, 16'h0000);
        tick();
        // the entry pushed before reset must be gone
        checks++;
        if ({output_PC, output_branchTaken, output_rasError} !== {16'h0000, 2'b01}) begin
            errors++;
            $display("FAIL lost_entry pc=%h tk=%b err=%b exp pc=0000 tk=0 err=1",
                     output_PC, output_branchTaken, output_rasError);
        end
        $display("post reset ret pc=%h err=%b", output_PC, output_rasError);
    endtask

    initial begin
        RST_N            = 1'b0;
        input_PCWrite    = 1'b0;
        input_mode       = 2'b00;
        input_branchType = 3'b000;
        input_newPC      = 16'h0000;
        input_returnAddr = 16'h0000;
        input_zero       = 1'b0;
        input_negative   = 1'b0;
        test_reset();
        test_cond_sweep();
        test_enable_gating();
        test_nested_calls();
        test_overflow();
        test_underflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
